// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that lets two masters share the single Avalon-style slave port of the SDRAM controller.
// Read responses come back in order and are steered to the issuing master through a 1-bit tag FIFO.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int BE_W        = 2,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_be_n,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_rd_n,
  input  logic              m0_wr_n,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_be_n,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_rd_n,
  input  logic              m1_wr_n,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_valid,
  output logic [ADDR_W-1:0] az_addr,
  output logic [BE_W-1:0]   az_be_n,
  output logic [DATA_W-1:0] az_data,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,
  output logic              err_underflow
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(MAX_PENDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_PENDING - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                   state, state_nxt;
  logic                     gnt, gnt_nxt;
  logic                     last, last_nxt;
  logic [MAX_PENDING-1:0]   tag_mem;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     push, pop, head;
  logic                     elig0, elig1;

  logic [ADDR_W-1:0]        sel_addr;
  logic [BE_W-1:0]          sel_be_n;
  logic [DATA_W-1:0]        sel_data;
  logic                     sel_rd_n, sel_wr_n, sel_is_rd, sel_active;

  // A read is only eligible while a tag slot is free (registered count, so one cycle conservative).
  assign elig0 = ~m0_wr_n | (~m0_rd_n & (count < FULL));
  assign elig1 = ~m1_wr_n | (~m1_rd_n & (count < FULL));

  assign sel_addr   = gnt ? m1_addr : m0_addr;
  assign sel_be_n   = gnt ? m1_be_n : m0_be_n;
  assign sel_data   = gnt ? m1_data : m0_data;
  assign sel_rd_n   = gnt ? m1_rd_n : m0_rd_n;
  assign sel_wr_n   = gnt ? m1_wr_n : m0_wr_n;
  // Read and write asserted together is forwarded as a write only.
  assign sel_is_rd  = ~sel_rd_n & sel_wr_n;
  assign sel_active = ~sel_rd_n | ~sel_wr_n;

  assign pop      = za_valid & (count != '0);
  assign head     = tag_mem[rd_ptr];
  assign m0_valid = pop & ~head;
  assign m1_valid = pop & head;
  assign m0_rdata = za_data;
  assign m1_rdata = za_data;

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_nxt       = last;
    push           = 1'b0;
    az_addr        = '0;
    az_data        = '0;
    az_be_n        = '1;
    az_rd_n        = 1'b1;
    az_wr_n        = 1'b1;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          state_nxt = ISSUE;
          gnt_nxt   = (elig0 & elig1) ? ~last : elig1;
        end
      end
      ISSUE: begin
        az_addr = sel_addr;
        az_data = sel_data;
        az_be_n = sel_be_n;
        az_wr_n = sel_wr_n;
        az_rd_n = ~sel_is_rd;
        if (gnt) m1_waitrequest = za_waitrequest;
        else     m0_waitrequest = za_waitrequest;
        // A master that abandons its command simply loses the slot.
        if (!sel_active) begin
          state_nxt = IDLE;
        end else if (!za_waitrequest) begin
          state_nxt = IDLE;
          last_nxt  = gnt;
          push      = sel_is_rd;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      last          <= 1'b1;
      tag_mem       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      if (push) begin
        tag_mem[wr_ptr] <= gnt;
        wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (za_valid && count == '0) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a randomized run
// checked against a master/controller scoreboard.
module tb_sdram_port_arbiter;

  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 16;
  localparam int BE_W        = 2;
  localparam int MAX_PENDING = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_addr, m1_addr, az_addr;
  logic [BE_W-1:0]   m0_be_n, m1_be_n, az_be_n;
  logic [DATA_W-1:0] m0_data, m1_data, az_data, za_data, m0_rdata, m1_rdata;
  logic              m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n;
  logic              m0_waitrequest, m1_waitrequest, m0_valid, m1_valid;
  logic              az_rd_n, az_wr_n, za_valid, za_waitrequest, err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_be_n(m0_be_n), .m0_data(m0_data), .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n),
    .m0_waitrequest(m0_waitrequest), .m0_rdata(m0_rdata), .m0_valid(m0_valid),
    .m1_addr(m1_addr), .m1_be_n(m1_be_n), .m1_data(m1_data), .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n),
    .m1_waitrequest(m1_waitrequest), .m1_rdata(m1_rdata), .m1_valid(m1_valid),
    .az_addr(az_addr), .az_be_n(az_be_n), .az_data(az_data), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
    .za_data(za_data), .za_valid(za_valid), .za_waitrequest(za_waitrequest),
    .err_underflow(err_underflow)
  );

  // Controller read data is a fixed function of the address so every response is predictable.
  function automatic logic [DATA_W-1:0] resp_data(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[21:16], 10'h1a5};
  endfunction

  task automatic idle_inputs();
    m0_addr = '0; m0_be_n = '1; m0_data = '0; m0_rd_n = 1'b1; m0_wr_n = 1'b1;
    m1_addr = '0; m1_be_n = '1; m1_data = '0; m1_rd_n = 1'b1; m1_wr_n = 1'b1;
    za_data = '0; za_valid = 1'b0; za_waitrequest = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    m0_wr_n = 1'b0; m1_rd_n = 1'b0; za_valid = 1'b1; za_data = 16'hffff;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({m0_waitrequest, m1_waitrequest, az_rd_n, az_wr_n} !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 1111", {m0_waitrequest, m1_waitrequest, az_rd_n, az_wr_n});
    end
    n_checks++;
    if ({m0_valid, m1_valid, err_underflow} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_valid_err: got %b expected 000", {m0_valid, m1_valid, err_underflow});
    end
    n_checks++;
    if (az_addr !== '0 || az_be_n !== '1 || az_data !== '0) begin
      n_fail++; $display("[TB] FAIL reset_az_bus: got addr=%h be_n=%b data=%h expected 0/11/0", az_addr, az_be_n, az_data);
    end
    tick();
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m0_waitrequest, m1_waitrequest, az_rd_n, az_wr_n, err_underflow} !== 5'b11110) begin
      n_fail++; $display("[TB] FAIL reset_release_idle: got %b expected 11110", {m0_waitrequest, m1_waitrequest, az_rd_n, az_wr_n, err_underflow});
    end
    tick();
  endtask

  task automatic test_single_write();
    m0_addr = 22'h00babe; m0_data = 16'hd00d; m0_be_n = 2'b00; m0_wr_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0_waitrequest !== 1'b1 || az_wr_n !== 1'b1) begin
      n_fail++; $display("[TB] FAIL write_idle_cycle: got wait=%b az_wr_n=%b expected 1/1", m0_waitrequest, az_wr_n);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (az_addr !== 22'h00babe || az_data !== 16'hd00d || az_be_n !== 2'b00) begin
      n_fail++; $display("[TB] FAIL write_az_bus: got addr=%h data=%h be_n=%b expected 00babe/d00d/00", az_addr, az_data, az_be_n);
    end
    n_checks++;
    if ({az_wr_n, az_rd_n, m0_waitrequest, m1_waitrequest} !== 4'b0101) begin
      n_fail++; $display("[TB] FAIL write_strobes: got %b expected 0101", {az_wr_n, az_rd_n, m0_waitrequest, m1_waitrequest});
    end
    tick();
    m0_wr_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({az_wr_n, m0_waitrequest} !== 2'b11 || az_addr !== '0) begin
      n_fail++; $display("[TB] FAIL write_back_idle: got wr_n/wait=%b addr=%h expected 11/0", {az_wr_n, m0_waitrequest}, az_addr);
    end
    tick();
  endtask

  task automatic test_alternate();
    int exp_m, last_cyc, grants, g;
    do_reset();
    m0_addr = 22'h000111; m0_data = 16'haaaa; m0_be_n = 2'b00; m0_wr_n = 1'b0;
    m1_addr = 22'h000222; m1_data = 16'hbbbb; m1_be_n = 2'b00; m1_wr_n = 1'b0;
    exp_m = 0; last_cyc = -1; grants = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (!m0_waitrequest || !m1_waitrequest) begin
        g = m1_waitrequest ? 0 : 1;
        n_checks++;
        if (g != exp_m || az_addr !== (g == 1 ? 22'h000222 : 22'h000111)) begin
          n_fail++; $display("[TB] FAIL alt_grant: cycle %0d got master %0d addr %h expected master %0d", cyc, g, az_addr, exp_m);
        end
        if (last_cyc >= 0) begin
          n_checks++;
          if (cyc - last_cyc != 2) begin
            n_fail++; $display("[TB] FAIL alt_spacing: got %0d cycles expected 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc; exp_m ^= 1; grants++;
      end
      tick();
    end
    m0_wr_n = 1'b1; m1_wr_n = 1'b1;
    n_checks++;
    if (grants != 8) begin
      n_fail++; $display("[TB] FAIL alt_count: got %0d grants expected 8", grants);
    end
  endtask

  task automatic test_read_routing();
    int order[$];
    int exp_m;
    bit done0, done1, g0, g1;
    do_reset();
    m0_addr = 22'd10; m0_rd_n = 1'b0;
    m1_addr = 22'd20; m1_rd_n = 1'b0;
    done0 = 0; done1 = 0;
    for (int cyc = 0; cyc < 10 && !(done0 && done1); cyc++) begin
      @(negedge clk);
      g0 = !m0_waitrequest; g1 = !m1_waitrequest;
      if (g0 || g1) begin
        n_checks++;
        if (az_rd_n !== 1'b0 || az_addr !== (g1 ? 22'd20 : 22'd10)) begin
          n_fail++; $display("[TB] FAIL route_issue: got rd_n=%b addr=%h", az_rd_n, az_addr);
        end
        order.push_back(g1 ? 1 : 0);
      end
      tick();
      if (g0) begin done0 = 1; m0_rd_n = 1'b1; end
      if (g1) begin done1 = 1; m1_rd_n = 1'b1; end
    end
    n_checks++;
    if (order.size() != 2 || order[0] != 0) begin
      n_fail++; $display("[TB] FAIL route_order: got %0d grants first=%0d expected 2 grants first=0", order.size(), order.size() > 0 ? order[0] : -1);
    end
    za_valid = 1'b1; za_data = 16'h1111;
    for (int k = 0; k < 2; k++) begin
      exp_m = (order.size() > 0) ? order.pop_front() : 0;
      @(negedge clk);
      n_checks++;
      if ({m1_valid, m0_valid} !== (exp_m == 1 ? 2'b10 : 2'b01) || (exp_m == 1 ? m1_rdata : m0_rdata) !== za_data) begin
        n_fail++; $display("[TB] FAIL route_resp%0d: got valid(m1,m0)=%b data=%h expected master %0d data %h", k, {m1_valid, m0_valid}, exp_m == 1 ? m1_rdata : m0_rdata, exp_m, za_data);
      end
      tick();
      za_data = 16'h2222;
    end
    za_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m0_valid, m1_valid, err_underflow} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL route_after: got %b expected 000", {m0_valid, m1_valid, err_underflow});
    end
    tick();
  endtask

  task automatic test_pending_limit();
    int accepted, m0_grants, leaks, found;
    bit got;
    logic [DATA_W-1:0] d;
    do_reset();
    m1_addr = ADDR_W'($urandom); m1_rd_n = 1'b0;
    accepted = 0;
    for (int i = 0; i < 40 && accepted < MAX_PENDING; i++) begin
      @(negedge clk);
      got = !m1_waitrequest;
      tick();
      if (got) begin accepted++; m1_addr = ADDR_W'($urandom); end
    end
    n_checks++;
    if (accepted != MAX_PENDING) begin
      n_fail++; $display("[TB] FAIL full_fill: got %0d reads accepted expected %0d", accepted, MAX_PENDING);
    end
    m0_addr = 22'h003333; m0_data = 16'h4444; m0_be_n = 2'b00; m0_wr_n = 1'b0;
    m0_grants = 0; leaks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!m1_waitrequest) leaks++;
      if (!m0_waitrequest) m0_grants++;
      tick();
    end
    m0_wr_n = 1'b1;
    n_checks++;
    if (leaks != 0 || m0_grants != 4) begin
      n_fail++; $display("[TB] FAIL full_hold: got m1 grants=%0d m0 grants=%0d expected 0/4", leaks, m0_grants);
    end
    d = DATA_W'($urandom);
    za_valid = 1'b1; za_data = d;
    @(negedge clk);
    n_checks++;
    if ({m1_valid, m0_valid} !== 2'b10 || m1_rdata !== d) begin
      n_fail++; $display("[TB] FAIL full_pop: got valid(m1,m0)=%b data=%h expected 10 data=%h", {m1_valid, m0_valid}, m1_rdata, d);
    end
    tick();
    za_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 4 && found == 0; i++) begin
      @(negedge clk);
      if (!m1_waitrequest && az_rd_n === 1'b0 && az_addr === m1_addr) found = 1;
      tick();
    end
    m1_rd_n = 1'b1;
    n_checks++;
    if (found == 0) begin
      n_fail++; $display("[TB] FAIL full_resume: got no read grant within 4 cycles expected grant");
    end
  endtask

  task automatic test_underflow_stall();
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    do_reset();
    za_valid = 1'b1; za_data = 16'hbeef;
    @(negedge clk);
    n_checks++;
    if ({m0_valid, m1_valid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL underflow_drop: got valid=%b expected 00", {m0_valid, m1_valid});
    end
    tick();
    za_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_underflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL underflow_flag: got %b expected 1", err_underflow);
    end
    a1 = ADDR_W'($urandom); d1 = DATA_W'($urandom);
    za_waitrequest = 1'b1;
    m1_addr = a1; m1_data = d1; m1_be_n = 2'b01; m1_wr_n = 1'b0;
    tick();
    m0_addr = ~a1; m0_data = ~d1; m0_be_n = 2'b10; m0_wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (az_addr !== a1 || az_data !== d1 || az_be_n !== 2'b01 || {az_wr_n, m0_waitrequest, m1_waitrequest, err_underflow} !== 4'b0111) begin
        n_fail++; $display("[TB] FAIL stall_hold%0d: got addr=%h data=%h flags=%b expected %h/%h/0111", i, az_addr, az_data, {az_wr_n, m0_waitrequest, m1_waitrequest, err_underflow}, a1, d1);
      end
      tick();
    end
    za_waitrequest = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m1_waitrequest !== 1'b0 || az_addr !== a1) begin
      n_fail++; $display("[TB] FAIL stall_release: got wait=%b addr=%h expected 0/%h", m1_waitrequest, az_addr, a1);
    end
    tick();
    m1_wr_n = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (m0_waitrequest !== 1'b0 || az_addr !== ~a1) begin
      n_fail++; $display("[TB] FAIL stall_next_m0: got wait=%b addr=%h expected 0/%h", m0_waitrequest, az_addr, ~a1);
    end
    tick();
    m0_wr_n = 1'b1;
    m0_addr = 22'h000abc; m0_rd_n = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    m0_rd_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (err_underflow !== 1'b0 || m0_waitrequest !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midreset_clear: got err=%b wait=%b expected 0/1", err_underflow, m0_waitrequest);
    end
    #1 reset_n = 1'b1;
    tick();
    za_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m0_valid, m1_valid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL midreset_tag_discard: got valid=%b expected 00", {m0_valid, m1_valid});
    end
    tick();
    za_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_underflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midreset_underflow: got %b expected 1", err_underflow);
    end
    tick();
  endtask

  task automatic test_illegal_both();
    do_reset();
    m0_addr = 22'h001234; m0_rd_n = 1'b0; m0_wr_n = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if ({az_wr_n, az_rd_n, m0_waitrequest} !== 3'b010) begin
      n_fail++; $display("[TB] FAIL illegal_forward: got wr_n/rd_n/wait=%b expected 010", {az_wr_n, az_rd_n, m0_waitrequest});
    end
    tick();
    m0_rd_n = 1'b1; m0_wr_n = 1'b1;
    za_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m0_valid, m1_valid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL illegal_no_tag: got valid=%b expected 00", {m0_valid, m1_valid});
    end
    tick();
    za_valid = 1'b0;
  endtask

  task automatic test_random();
    logic              act[2], c_rd[2], acc[2];
    logic [ADDR_W-1:0] c_addr[2];
    logic [DATA_W-1:0] c_data[2];
    logic [BE_W-1:0]   c_be[2];
    logic [ADDR_W-1:0] rq0[$], rq1[$], ctl_q[$];
    logic [DATA_W-1:0] exp_d;
    logic [1:0]        wreq;
    bit allow;
    do_reset();
    for (int m = 0; m < 2; m++) begin act[m] = 0; c_rd[m] = 0; c_addr[m] = '0; c_data[m] = '0; c_be[m] = '1; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      allow = (cyc < 500);
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && allow && $urandom_range(0, 2) != 0) begin
          act[m] = 1'b1; c_rd[m] = 1'($urandom_range(0, 1));
          c_addr[m] = ADDR_W'($urandom); c_data[m] = DATA_W'($urandom); c_be[m] = BE_W'($urandom);
        end
      end
      m0_addr = c_addr[0]; m0_data = c_data[0]; m0_be_n = c_be[0];
      m0_rd_n = ~(act[0] & c_rd[0]); m0_wr_n = ~(act[0] & ~c_rd[0]);
      m1_addr = c_addr[1]; m1_data = c_data[1]; m1_be_n = c_be[1];
      m1_rd_n = ~(act[1] & c_rd[1]); m1_wr_n = ~(act[1] & ~c_rd[1]);
      za_waitrequest = allow ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (ctl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        za_valid = 1'b1; za_data = resp_data(ctl_q.pop_front());
      end else begin
        za_valid = 1'b0; za_data = DATA_W'($urandom);
      end
      @(negedge clk);
      n_checks++;
      if (int'(m0_valid) + int'(m1_valid) != (za_valid ? 1 : 0)) begin
        n_fail++; $display("[TB] FAIL rand_valid_count: got valid(m1,m0)=%b for za_valid=%b", {m1_valid, m0_valid}, za_valid);
      end
      if (m0_valid) begin
        n_checks++;
        if (rq0.size() == 0) begin
          n_fail++; $display("[TB] FAIL rand_m0_spurious: got valid with no read outstanding");
        end else begin
          exp_d = resp_data(rq0.pop_front());
          if (m0_rdata !== exp_d) begin
            n_fail++; $display("[TB] FAIL rand_m0_data: got %h expected %h", m0_rdata, exp_d);
          end
        end
      end
      if (m1_valid) begin
        n_checks++;
        if (rq1.size() == 0) begin
          n_fail++; $display("[TB] FAIL rand_m1_spurious: got valid with no read outstanding");
        end else begin
          exp_d = resp_data(rq1.pop_front());
          if (m1_rdata !== exp_d) begin
            n_fail++; $display("[TB] FAIL rand_m1_data: got %h expected %h", m1_rdata, exp_d);
          end
        end
      end
      wreq = {m1_waitrequest, m0_waitrequest};
      n_checks++;
      if (wreq == 2'b00) begin
        n_fail++; $display("[TB] FAIL rand_double_grant: got both waitrequest low expected at most one");
      end
      for (int m = 0; m < 2; m++) begin
        acc[m] = 1'b0;
        if (!wreq[m]) begin
          n_checks++;
          if (!act[m] || az_addr !== c_addr[m] || az_data !== c_data[m] || az_be_n !== c_be[m] ||
              az_rd_n !== ~c_rd[m] || az_wr_n !== c_rd[m]) begin
            n_fail++; $display("[TB] FAIL rand_forward_m%0d: got addr=%h data=%h rd_n=%b wr_n=%b expected act=%b addr=%h data=%h rd=%b",
                               m, az_addr, az_data, az_rd_n, az_wr_n, act[m], c_addr[m], c_data[m], c_rd[m]);
          end else begin
            acc[m] = 1'b1;
            if (c_rd[m]) begin
              if (m == 0) rq0.push_back(c_addr[m]); else rq1.push_back(c_addr[m]);
              ctl_q.push_back(c_addr[m]);
            end
          end
        end
      end
      n_checks++;
      if (rq0.size() + rq1.size() > MAX_PENDING) begin
        n_fail++; $display("[TB] FAIL rand_pending_limit: got %0d outstanding expected <= %0d", rq0.size() + rq1.size(), MAX_PENDING);
      end
      tick();
      for (int m = 0; m < 2; m++) if (acc[m]) act[m] = 1'b0;
    end
    n_checks++;
    if (act[0] || act[1] || rq0.size() != 0 || rq1.size() != 0 || ctl_q.size() != 0 || err_underflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rand_drain: got act=%b%b rq0=%0d rq1=%0d ctl=%0d err=%b expected all clear",
                         act[1], act[0], rq0.size(), rq1.size(), ctl_q.size(), err_underflow);
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_read_routing();
    test_pending_limit();
    test_underflow_stall();
    test_illegal_both();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
